// File: rtl/decomposer_unit.sv
// decomposer_unit: four-lane pipelined Dilithium Decompose, r = r1*alpha + r0 (mod q)
module decomposer_unit #(
    parameter int OUTPUT_W = 4,
    parameter int COEFF_W  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   sec_lvl,
    input  logic                         valid_i,
    output logic                         ready_i,
    input  logic [OUTPUT_W*COEFF_W-1:0]  di,
    output logic [OUTPUT_W*COEFF_W-1:0]  doa,
    output logic [OUTPUT_W*COEFF_W-1:0]  dob,
    output logic                         valid_o,
    input  logic                         ready_o
);
    localparam int DW = COEFF_W + 1;

    logic                         en;
    logic                         s1_v, s2_v, s3_v;
    logic                         s1_88, s2_88;
    logic [OUTPUT_W*COEFF_W-1:0]  s1_r, s2_r;
    logic [OUTPUT_W*6-1:0]        s2_t, s3_r1;
    logic [OUTPUT_W*DW-1:0]       s3_d;
    logic [OUTPUT_W*6-1:0]        t_c, r1_c;
    logic [OUTPUT_W*DW-1:0]       d_c;
    logic [OUTPUT_W*COEFF_W-1:0]  a_c, b_c;

    assign en      = ready_o | ~valid_o;
    assign ready_i = rst & en;

    for (genvar g = 0; g < OUTPUT_W; g++) begin : g_lane
        logic [DW-1:0] x;
        logic [31:0]   p1, p2, ta;
        logic [5:0]    t;
        logic          wrap;
        logic [DW-1:0] d;
        // Rounded quotient floor((r + alpha/2 - 1)/alpha) gives the centred remainder.
        // alpha = 512*1023 or 2048*93: shift out the power of two, then an exact reciprocal multiply.
        assign x  = {1'b0, s1_r[g*COEFF_W +: COEFF_W]} + (s1_88 ? DW'(95231) : DW'(261887));
        assign p1 = 32'(x >> 9) * 32'd32801;
        assign p2 = 32'(x >> 11) * 32'd11276;
        assign t_c[g*6 +: 6] = s1_88 ? 6'(p2 >> 20) : 6'(p1 >> 25);
        // r1*alpha == q-1 only at the top quotient; that case folds to r1 = 0, r0 = r0' - 1.
        assign t    = s2_t[g*6 +: 6];
        assign wrap = s2_88 ? (t == 6'd44) : (t == 6'd16);
        assign ta   = 32'(t) * (s2_88 ? 32'd190464 : 32'd523776);
        assign d_c[g*DW +: DW] = DW'(32'(s2_r[g*COEFF_W +: COEFF_W]) - ta - 32'(wrap));
        assign r1_c[g*6 +: 6]  = wrap ? 6'd0 : t;
        // Negative r0 is mapped into [0,q) by adding q.
        assign d = s3_d[g*DW +: DW];
        assign b_c[g*COEFF_W +: COEFF_W] = d[DW-1] ? COEFF_W'(d + DW'(8380417)) : COEFF_W'(d);
        assign a_c[g*COEFF_W +: COEFF_W] = COEFF_W'(s3_r1[g*6 +: 6]);
    end

    // Valid flags shift together on the shared enable; bubbles shift in as zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            valid_o <= 1'b0;
        end else if (en) begin
            s1_v    <= valid_i;
            s2_v    <= s1_v;
            s3_v    <= s2_v;
            valid_o <= s3_v;
        end
    end

    // Datapath registers advance with the enable; outputs only load when a real word arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_88 <= 1'b0;
            s2_88 <= 1'b0;
            s1_r  <= '0;
            s2_r  <= '0;
            s2_t  <= '0;
            s3_r1 <= '0;
            s3_d  <= '0;
            doa   <= '0;
            dob   <= '0;
        end else if (en) begin
            s1_88 <= (sec_lvl == 3'b010);
            s1_r  <= di;
            s2_88 <= s1_88;
            s2_r  <= s1_r;
            s2_t  <= t_c;
            s3_r1 <= r1_c;
            s3_d  <= d_c;
            if (s3_v) begin
                doa <= a_c;
                dob <= b_c;
            end
        end
    end
endmodule

// File: tb/tb_decomposer_unit.sv
// tb_decomposer_unit: directed vectors plus a reference model checked on every output cycle
module tb_decomposer_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sec_lvl;
    logic        valid_i;
    logic        ready_i;
    logic [95:0] di;
    logic [95:0] doa;
    logic [95:0] dob;
    logic        valid_o;
    logic        ready_o;

    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    logic [95:0] exp_a[$];
    logic [95:0] exp_b[$];
    logic [95:0] last_a = '0;
    logic [95:0] last_b = '0;

    decomposer_unit dut (
        .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .valid_i(valid_i), .ready_i(ready_i),
        .di(di), .doa(doa), .dob(dob), .valid_o(valid_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] dec(input int r, input logic is88);
        int a;
        int r0;
        int r1;
        a  = is88 ? 190464 : 523776;
        r0 = r % a;
        if (r0 > a / 2) r0 = r0 - a;
        r1 = (r - r0) / a;
        if (r - r0 == 8380416) begin
            r1 = 0;
            r0 = r0 - 1;
        end
        if (r0 < 0) r0 = r0 + 8380417;
        return {24'(r1), 24'(r0)};
    endfunction

    function automatic logic [191:0] model(input logic [2:0] s, input logic [95:0] d);
        logic [191:0] o;
        logic [47:0]  e;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            e = dec(int'(d[i*24 +: 24]), s == 3'd2);
            o[96 + i*24 +: 24] = e[47:24];
            o[i*24 +: 24]      = e[23:0];
        end
        return o;
    endfunction

    function automatic logic [95:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {24'(a3), 24'(a2), 24'(a1), 24'(a0)};
    endfunction

    function automatic logic [95:0] rnd_word();
        logic [95:0] w;
        for (int i = 0; i < 4; i++) w[i*24 +: 24] = 24'($urandom_range(0, 8380416));
        return w;
    endfunction

    // compare process: every cycle, against the model queue
    always @(negedge clk) begin
        logic [191:0] m;
        if (!rst) begin
            exp_a.delete();
            exp_b.delete();
            last_a = '0;
            last_b = '0;
            chk("rst_valid_o", 96'(valid_o), 96'(0));
        end else begin
            chk("ready_i", 96'(ready_i), 96'(ready_o || !valid_o));
            if (valid_o) begin
                if (exp_a.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got valid_o=1 expected no word pending");
                end else begin
                    chk("doa", doa, exp_a[0]);
                    chk("dob", dob, exp_b[0]);
                    if (ready_o) begin
                        last_a = exp_a.pop_front();
                        last_b = exp_b.pop_front();
                        n_out++;
                    end
                end
            end else begin
                chk("doa_hold", doa, last_a);
                chk("dob_hold", dob, last_b);
            end
            if (valid_i && ready_i) begin
                m = model(sec_lvl, di);
                exp_a.push_back(m[191:96]);
                exp_b.push_back(m[95:0]);
            end
        end
    end

    task automatic one_word(input logic [2:0] s, input logic [95:0] d,
                            input logic [95:0] ea, input logic [95:0] eb);
        sec_lvl = s;
        di      = d;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lat_early", 96'(valid_o), 96'(0));
        @(posedge clk); #1;
        chk("lat_valid", 96'(valid_o), 96'(1));
        chk("lit_doa", doa, ea);
        chk("lit_dob", dob, eb);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [191:0] m;
        logic [95:0]  w, ha, hb;
        int idx, k, n0;
        logic acc, stall;
        rst = 1'b0; valid_i = 1'b0; ready_o = 1'b1; sec_lvl = 3'd0; di = '0;
        m = model(3'd0, pk(0, 261888, 261889, 8380416));
        chk("model_pin_a", m[191:96], pk(0, 0, 1, 0));
        chk("model_pin_b", m[95:0], pk(0, 'h3FF00, 'h7BE102, 'h7FE000));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_i", 96'(ready_i), 96'(0));
        chk("rst_doa", doa, '0);
        chk("rst_dob", dob, '0);
        chk("rst_valid", 96'(valid_o), 96'(0));
        rst = 1'b1;
        #1;
        chk("idle_ready_i", 96'(ready_i), 96'(1));
        @(posedge clk); #1;

        one_word(3'd0, pk(0, 261888, 261889, 8380416), pk(0, 0, 1, 0),
                 pk(0, 'h3FF00, 'h7BE102, 'h7FE000));
        one_word(3'd2, pk(95233, 190464, 8380416, 95232), pk(1, 1, 0, 0),
                 pk('h7E6C02, 0, 'h7FE000, 'h17400));

        for (int j = 0; j < 12; j++) begin
            valid_i = (j < 8);
            if (j < 8) begin
                di = rnd_word();
                sec_lvl = j[0] ? 3'd2 : 3'd3;
            end
            @(posedge clk); #1;
            chk("stream_valid", 96'(valid_o), 96'(j >= 3 && j <= 10));
        end
        valid_i = 1'b0;

        n0 = n_out; idx = 0; k = 0; w = rnd_word();
        while (idx < 8 && k < 60) begin
            ready_o = !(k >= 5 && k < 10);
            valid_i = 1'b1;
            di = w;
            sec_lvl = idx[0] ? 3'd2 : 3'd5;
            #1;
            acc = ready_i;
            stall = valid_o && !ready_o;
            ha = doa;
            hb = dob;
            if (stall) chk("bp_ready_i", 96'(ready_i), 96'(0));
            @(posedge clk); #1;
            if (stall) begin
                chk("bp_hold_v", 96'(valid_o), 96'(1));
                chk("bp_hold_a", doa, ha);
                chk("bp_hold_b", dob, hb);
            end
            if (acc) begin
                idx++;
                w = rnd_word();
            end
            k++;
        end
        valid_i = 1'b0;
        ready_o = 1'b1;
        chk("bp_all_sent", 96'(idx), 96'(8));
        repeat (6) @(posedge clk);
        #1;
        chk("bp_count", 96'(n_out - n0), 96'(8));
        chk("bp_drained", 96'(exp_a.size()), 96'(0));

        for (int j = 0; j < 4; j++) begin
            valid_i = 1'b1;
            di = rnd_word();
            sec_lvl = 3'd0;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        chk("pre_rst_valid", 96'(valid_o), 96'(1));
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", 96'(valid_o), 96'(0));
        chk("arst_doa", doa, '0);
        chk("arst_dob", dob, '0);
        chk("arst_ready_i", 96'(ready_i), 96'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        one_word(3'd0, pk(523776, 785664, 100, 8380000), pk(1, 1, 0, 0),
                 pk(0, 'h3FF00, 'h64, 'h7FDE60));
        repeat (2) @(posedge clk);
        #1;
        chk("final_drained", 96'(exp_a.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
